// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the uart transmit path.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, modulo N.
module rr_pick #(
  parameter  int unsigned N  = 2,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW-1:0] cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = PW'((32'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin arbiter sharing one uart transmitter among N_REQ
// requesters, with a stall watchdog that revokes an abandoned grant.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned N_REQ   = 2,
  parameter  int unsigned TIMEOUT = 1024,
  localparam int unsigned GW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [DATA_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_valid,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic [GW-1:0]           grant_id,
  output logic                    timeout_pulse
);

  localparam int unsigned CW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned LIMIT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  arb_state_e        state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     stall_cnt_q, stall_cnt_d;
  logic              timeout_q, timeout_d;

  logic [DATA_W-1:0] data_arr [N_REQ];
  logic [GW-1:0]     pick_idx;
  logic              pick_any;
  logic              locked;
  logic              sel_valid;
  logic              sel_last;
  logic              xfer;
  logic [GW-1:0]     ptr_wrap;
  logic [CW:0]       stall_nxt;
  logic              stall_hit;
  logic [CW-1:0]     stall_inc;

  for (genvar i = 0; i < N_REQ; i++) begin : g_data
    assign data_arr[i] = req_data[DATA_W*i +: DATA_W];
  end

  rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Granted requester is wired straight through to the uart; nothing is driven while idle.
  assign locked    = (state_q == ST_LOCKED);
  assign sel_valid = req_valid[grant_q];
  assign sel_last  = req_last[grant_q];
  assign tx_valid  = locked && sel_valid;
  assign tx_data   = locked ? data_arr[grant_q] : '0;
  assign req_ready = (locked && tx_ready) ? (N_REQ'(1) << grant_q) : '0;
  assign xfer      = tx_valid && tx_ready;

  assign busy          = locked;
  assign grant_id      = grant_q;
  assign timeout_pulse = timeout_q;

  assign ptr_wrap  = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + GW'(1);
  assign stall_nxt = {1'b0, stall_cnt_q} + (CW + 1)'(1);
  assign stall_hit = (stall_nxt >= (CW + 1)'(LIMIT));
  assign stall_inc = (stall_cnt_q == '1) ? stall_cnt_q : stall_nxt[CW-1:0];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    stall_cnt_d = stall_cnt_q;
    timeout_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d     = ST_LOCKED;
          grant_d     = pick_idx;
          stall_cnt_d = '0;
        end
      end
      ST_LOCKED: begin
        if (xfer) begin
          stall_cnt_d = '0;
          if (sel_last) begin
            state_d = ST_IDLE;
            ptr_d   = ptr_wrap;
          end
        end else if (!sel_valid && (TIMEOUT != 0)) begin
          // Only cycles with no byte offered count; uart back-pressure is not a stall.
          stall_cnt_d = stall_inc;
          if (stall_hit) begin
            state_d     = ST_IDLE;
            ptr_d       = ptr_wrap;
            stall_cnt_d = '0;
            timeout_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a message-level reference model.
module tb_uart_tx_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [23:0] req_data;
  logic [2:0]  req_last;
  logic [2:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_pulse;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(
    .N_REQ   (N),
    .TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .grant_id      (grant_id),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the uart, the rotation start, and how long the owner has been silent.
  bit m_lock;
  int m_grant, m_ptr, m_stall;
  bit m_pulse;

  task automatic model_reset();
    m_lock = 0; m_grant = 0; m_ptr = 0; m_stall = 0; m_pulse = 0;
  endtask

  task automatic model_check();
    logic       e_txv;
    logic [7:0] e_txd;
    logic [2:0] e_rdy;
    e_txv = m_lock && req_valid[m_grant];
    e_txd = m_lock ? req_data[8*m_grant +: 8] : 8'h00;
    e_rdy = (m_lock && tx_ready) ? 3'(1 << m_grant) : 3'b000;
    chk("rnd_tx_valid", tx_valid, e_txv);
    chk("rnd_tx_data", tx_data, e_txd);
    chk("rnd_req_ready", req_ready, e_rdy);
    chk("rnd_busy", busy, m_lock);
    chk("rnd_grant_id", grant_id, m_grant);
    chk("rnd_timeout_pulse", timeout_pulse, m_pulse);
  endtask

  task automatic model_step();
    m_pulse = 0;
    if (!m_lock) begin
      for (int k = 0; k < N; k++) begin
        int c = (m_ptr + k) % N;
        if (req_valid[c]) begin
          m_lock = 1; m_grant = c; m_stall = 0;
          break;
        end
      end
    end else if (req_valid[m_grant] && tx_ready) begin
      m_stall = 0;
      if (req_last[m_grant]) begin
        m_lock = 0; m_ptr = (m_grant + 1) % N;
      end
    end else if (!req_valid[m_grant]) begin
      m_stall++;
      if (m_stall >= TO - 1) begin
        m_lock = 0; m_ptr = (m_grant + 1) % N; m_pulse = 1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 3'b111; req_last = 3'b111; req_data = 24'hFFFFFF; tx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_timeout_pulse", timeout_pulse, 0);
    @(posedge clk);
    #1;
    req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit          rst_before;
    logic [2:0]  rv;
    logic [2:0]  rl;
    logic        tr;
    logic [23:0] d;
    logic        txv;
    logic [7:0]  txd;
    logic [2:0]  rdy;
    logic        bsy;
    logic [1:0]  gid;
    logic        tp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, logic [2:0] rv, logic [2:0] rl, logic tr, logic [23:0] d,
                              logic txv, logic [7:0] txd, logic [2:0] rdy, logic b,
                              logic [1:0] g, logic tp);
    vec_t v;
    v.rst_before = r; v.rv = rv; v.rl = rl; v.tr = tr; v.d = d;
    v.txv = txv; v.txd = txd; v.rdy = rdy; v.bsy = b; v.gid = g; v.tp = tp;
    return v;
  endfunction

  int exp_order[5] = '{0, 1, 2, 0, 1};

  initial begin
    int n;
    int p;
    rst = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;

    // Single requester 0x41,0x42,0x43, then rotation from ptr=1.
    tbl.push_back(mk(1, 3'b001, 3'b000, 0, 24'h000041, 0, 8'h00, 3'b000, 0, 0, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 1, 24'h000041, 1, 8'h41, 3'b001, 1, 0, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 0, 24'h000042, 1, 8'h42, 3'b000, 1, 0, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 1, 24'h000042, 1, 8'h42, 3'b001, 1, 0, 0));
    tbl.push_back(mk(0, 3'b001, 3'b001, 0, 24'h000043, 1, 8'h43, 3'b000, 1, 0, 0));
    tbl.push_back(mk(0, 3'b001, 3'b001, 1, 24'h000043, 1, 8'h43, 3'b001, 1, 0, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 1, 24'h000000, 0, 8'h00, 3'b000, 0, 0, 0));
    tbl.push_back(mk(0, 3'b011, 3'b000, 0, 24'h006050, 0, 8'h00, 3'b000, 0, 0, 0));
    tbl.push_back(mk(0, 3'b011, 3'b010, 1, 24'h006050, 1, 8'h60, 3'b010, 1, 1, 0));
    tbl.push_back(mk(0, 3'b011, 3'b000, 0, 24'h006050, 0, 8'h00, 3'b000, 0, 1, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 1, 24'h000051, 1, 8'h51, 3'b001, 1, 0, 0));
    tbl.push_back(mk(0, 3'b001, 3'b001, 1, 24'h000052, 1, 8'h52, 3'b001, 1, 0, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 0, 24'h000000, 0, 8'h00, 3'b000, 0, 0, 0));
    // Contention from ptr=0: r0's two bytes, then r1, then r0.
    tbl.push_back(mk(1, 3'b011, 3'b000, 0, 24'h00B0A0, 0, 8'h00, 3'b000, 0, 0, 0));
    tbl.push_back(mk(0, 3'b011, 3'b000, 1, 24'h00B0A0, 1, 8'hA0, 3'b001, 1, 0, 0));
    tbl.push_back(mk(0, 3'b011, 3'b001, 1, 24'h00B0A1, 1, 8'hA1, 3'b001, 1, 0, 0));
    tbl.push_back(mk(0, 3'b010, 3'b000, 1, 24'h00B0A1, 0, 8'h00, 3'b000, 0, 0, 0));
    tbl.push_back(mk(0, 3'b011, 3'b010, 1, 24'h00B0A2, 1, 8'hB0, 3'b010, 1, 1, 0));
    tbl.push_back(mk(0, 3'b011, 3'b001, 0, 24'h00B0A2, 0, 8'h00, 3'b000, 0, 1, 0));
    tbl.push_back(mk(0, 3'b011, 3'b001, 1, 24'h00B0A2, 1, 8'hA2, 3'b001, 1, 0, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 0, 24'h000000, 0, 8'h00, 3'b000, 0, 0, 0));

    foreach (tbl[i]) begin
      if (tbl[i].rst_before) do_reset();
      req_valid = tbl[i].rv; req_last = tbl[i].rl; tx_ready = tbl[i].tr; req_data = tbl[i].d;
      @(negedge clk);
      chk($sformatf("vec%0d_tx_valid", i), tx_valid, tbl[i].txv);
      chk($sformatf("vec%0d_tx_data", i), tx_data, tbl[i].txd);
      chk($sformatf("vec%0d_req_ready", i), req_ready, tbl[i].rdy);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("vec%0d_grant_id", i), grant_id, tbl[i].gid);
      chk($sformatf("vec%0d_timeout_pulse", i), timeout_pulse, tbl[i].tp);
      @(posedge clk); #1;
    end

    // Wrap-around: all three always requesting single-byte messages.
    do_reset();
    req_valid = 3'b111; req_last = 3'b111; req_data = 24'h333231; tx_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 5; c++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        chk("wrap_grant_id", grant_id, exp_order[n]);
        chk("wrap_tx_data", tx_data, 8'h31 + exp_order[n]);
        n++;
      end
      @(posedge clk); #1;
    end
    chk("wrap_count", n, 5);

    // Watchdog: r1 sends one non-last byte then goes silent while r0 waits.
    do_reset();
    req_valid = 3'b010; req_data = 24'h00C1D0; tx_ready = 1'b0;
    @(negedge clk);
    chk("wd_idle_busy", busy, 0);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(negedge clk);
    chk("wd_grant_id", grant_id, 1);
    chk("wd_req_ready", req_ready, 3'b010);
    @(posedge clk); #1;
    req_valid = 3'b001;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk($sformatf("wd_pulse_c%0d", c), timeout_pulse, (c == 8));
      chk($sformatf("wd_busy_c%0d", c), busy, (c != 8));
      chk($sformatf("wd_gid_c%0d", c), grant_id, (c == 9) ? 0 : 1);
      @(posedge clk); #1;
    end
    chk("wd_next_data", tx_data, 8'hD0);

    // Back-pressure: valid requester with uart not ready never times out.
    do_reset();
    req_valid = 3'b001; req_last = 3'b001; req_data = 24'h0000E5; tx_ready = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk("bp_busy", busy, 1);
      chk("bp_pulse", timeout_pulse, 0);
      chk("bp_req_ready", req_ready, 3'b000);
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    @(negedge clk);
    chk("bp_xfer_ready", req_ready, 3'b001);
    chk("bp_xfer_data", tx_data, 8'hE5);
    @(posedge clk); #1;
    req_valid = 3'b000;
    @(negedge clk);
    chk("bp_done_busy", busy, 0);
    chk("bp_done_pulse", timeout_pulse, 0);
    @(posedge clk); #1;

    // Async reset mid-message, after rotation has moved ptr away from 0.
    do_reset();
    req_valid = 3'b010; req_last = 3'b010; req_data = 24'h008877; tx_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = 3'b001; req_last = 3'b000;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rm_pre_busy", busy, 1);
    chk("rm_pre_grant", grant_id, 0);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    chk("rm_tx_valid", tx_valid, 0);
    chk("rm_tx_data", tx_data, 0);
    chk("rm_req_ready", req_ready, 0);
    chk("rm_busy", busy, 0);
    chk("rm_grant_id", grant_id, 0);
    chk("rm_timeout_pulse", timeout_pulse, 0);
    #3;
    rst = 1'b0;
    req_valid = 3'b110; req_last = 3'b000;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rm_regrant_id", grant_id, 1);
    chk("rm_regrant_busy", busy, 1);
    @(posedge clk); #1;

    // Randomized traffic against the reference model.
    do_reset();
    p = 90;
    for (int c = 0; c < 3000; c++) begin
      if (c % 40 == 0) begin
        case ($urandom_range(0, 2))
          0:       p = 90;
          1:       p = 50;
          default: p = 10;
        endcase
      end
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 99) < p);
        req_last[i]  = ($urandom_range(0, 3) == 0);
      end
      req_data = 24'($urandom);
      tx_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      model_check();
      model_step();
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
